pong_ball_ctrl: RTL and testbench
=================================

Name: pong_ball_ctrl

Overview:
- Ball-motion and rally controller for the Pong datapath.
- Sits directly downstream of the frame-rate tick counter, consuming its one-cycle `frame_tick` pulse.
- On each tick in play it advances the ball position, bounces the ball off the top/bottom walls and the paddles, and detects misses.
- Its outputs feed the pixel renderer (`ball_x`/`ball_y`) and the score counters (`score_l_evt`/`score_r_evt`).

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- BALL_SIZE, 8, ball square side in pixels
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_L_X, 16, left paddle left edge x
- PADDLE_R_X, 616, right paddle left edge x
- SPEED, 2, pixels moved per axis per frame_tick
- HOLD_FRAMES, 60, frame_ticks spent in POINT before returning to IDLE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, from the tick counter
- serve  in  1  one-cycle serve request (debounced button)
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball left edge x
- ball_y  out  10  ball top edge y
- in_play  out  1  high while state == PLAY
- score_l_evt  out  1  one-cycle pulse: left player scored
- score_r_evt  out  1  one-cycle pulse: right player scored

Behaviour:
- Reset is asynchronous, active-high, on clock clk. On reset:
  - ball_x = CX = (H_RES-BALL_SIZE)/2 = 316; ball_y = CY = (V_RES-BALL_SIZE)/2 = 236.
  - dx = +1 (right), dy = +1 (down).
  - State = IDLE; hold counter = 0; all event outputs = 0.
- Reset mid-rally aborts the rally immediately. No score pulse is generated.
- State machine:
  - IDLE: ball held at (CX,CY). serve=1 -> PLAY on the next edge. frame_tick in the same cycle causes no movement.
  - PLAY: on each frame_tick, update position and direction (rules below). On a miss -> POINT. serve is ignored.
  - POINT: ball frozen at its clamped edge. Counts frame_ticks. When the count reaches HOLD_FRAMES-1 and a tick arrives -> IDLE, ball recentred, count cleared. serve is ignored.
- Movement (PLAY, frame_tick=1): all outputs are registered. All compares use 11-bit unsigned arithmetic so a subtraction never wraps.
  - Vertical:
    - dy down and ball_y+SPEED >= V_RES-BALL_SIZE -> ball_y = V_RES-BALL_SIZE, dy = up.
    - dy up and ball_y < SPEED -> ball_y = 0, dy = down.
    - Otherwise ball_y += / -= SPEED.
  - Paddle overlap: (ball_y+BALL_SIZE > paddle_y) and (ball_y < paddle_y+PADDLE_H). It uses the pre-update ball_y and the current paddle input.
  - Left paddle hit: dx left, ball_x >= PADDLE_L_X+PADDLE_W, ball_x-SPEED <= PADDLE_L_X+PADDLE_W, and overlap -> ball_x = PADDLE_L_X+PADDLE_W, dx = right.
  - Right paddle hit: dx right, ball_x+BALL_SIZE <= PADDLE_R_X, ball_x+BALL_SIZE+SPEED >= PADDLE_R_X, and overlap -> ball_x = PADDLE_R_X-BALL_SIZE, dx = left.
  - Left miss: dx left and ball_x < SPEED -> ball_x = 0, score_r_evt pulses, state = POINT.
  - Right miss: dx right and ball_x+SPEED > H_RES-BALL_SIZE -> ball_x = H_RES-BALL_SIZE, score_l_evt pulses, state = POINT.
  - Otherwise ball_x += / -= SPEED.
  - Vertical and horizontal rules apply independently in the same tick (corner bounce allowed).
- Score pulses:
  - Asserted for exactly the one cycle after the detecting edge; never both at once.
  - At most one pulse per rally.
- Serve direction:
  - On entry to IDLE from POINT, dx is set toward the player who conceded: dx = left after score_r_evt, dx = right after score_l_evt.
  - dy keeps its last value.
- in_play equals (state == PLAY), registered.

Test Plan:
- Reset, then 5 frame_ticks with no serve -> ball stays at (316,236), in_play=0, no score pulses.
- Serve, then 3 ticks with paddle_r_y=200 -> ball at (322,242), in_play=1.
- Vertical bounce: ball at y=470 moving down, one tick -> y=472 and dy up; next tick -> y=470.
- Left paddle hit: ball at x=25 moving left, y=100, paddle_l_y=80, one tick -> x=24, dx right.
- Left miss: ball at x=1 moving left, paddle_l_y=300, y=100, one tick -> x=0 and score_r_evt=1 for exactly 1 cycle, state POINT. After 60 ticks -> IDLE at (316,236) with dx left.
- Assert reset mid-rally at (400,50) -> outputs immediately at (316,236), in_play=0, no score pulse. Serve and tick simultaneously -> PLAY with no movement that cycle.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// Pong ball motion and rally controller: advances the ball once per frame_tick,
// bounces it off walls and paddles, and pulses a score event on a miss.
module pong_ball_ctrl #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned PADDLE_L_X  = 16,
  parameter int unsigned PADDLE_R_X  = 616,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       score_l_evt,
  output logic       score_r_evt
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [10:0] Cx    = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] Cy    = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] Bs    = 11'(BALL_SIZE);
  localparam logic [10:0] Ph    = 11'(PADDLE_H);
  localparam logic [10:0] Sp    = 11'(SPEED);
  localparam logic [10:0] XMax  = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] YMax  = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] LFace = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] RFace = 11'(PADDLE_R_X);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StPoint} state_e;

  state_e           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d;  // 1 = right
  logic             dy_q, dy_d;  // 1 = down
  logic [HoldW-1:0] hold_q, hold_d;
  logic             score_l_q, score_l_d, score_r_q, score_r_d;
  logic             in_play_q, in_play_d;

  logic [10:0] x11, y11, pl11, pr11;
  logic        ovl_l, ovl_r;
  logic [9:0]  mx, my;
  logic        mdx, mdy, miss_l, miss_r;

  assign x11  = {1'b0, x_q};
  assign y11  = {1'b0, y_q};
  assign pl11 = {1'b0, paddle_l_y};
  assign pr11 = {1'b0, paddle_r_y};

  assign ovl_l = (y11 + Bs > pl11) && (y11 < pl11 + Ph);
  assign ovl_r = (y11 + Bs > pr11) && (y11 < pr11 + Ph);

  // Candidate motion for this tick; only committed in PLAY on frame_tick.
  always_comb begin
    my  = y_q;
    mdy = dy_q;
    if (dy_q) begin
      if (y11 + Sp >= YMax) begin
        my  = YMax[9:0];
        mdy = 1'b0;
      end else begin
        my = 10'(y11 + Sp);
      end
    end else begin
      if (y11 < Sp) begin
        my  = 10'd0;
        mdy = 1'b1;
      end else begin
        my = 10'(y11 - Sp);
      end
    end
  end

  always_comb begin
    mx     = x_q;
    mdx    = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dx_q) begin
      if (x11 >= LFace && x11 - Sp <= LFace && ovl_l) begin
        mx  = LFace[9:0];
        mdx = 1'b1;
      end else if (x11 < Sp) begin
        mx     = 10'd0;
        miss_l = 1'b1;
      end else begin
        mx = 10'(x11 - Sp);
      end
    end else begin
      if (x11 + Bs <= RFace && x11 + Bs + Sp >= RFace && ovl_r) begin
        mx  = 10'(RFace - Bs);
        mdx = 1'b0;
      end else if (x11 + Sp > XMax) begin
        mx     = XMax[9:0];
        miss_r = 1'b1;
      end else begin
        mx = 10'(x11 + Sp);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    hold_d    = hold_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        x_d = Cx[9:0];
        y_d = Cy[9:0];
        if (serve) state_d = StPlay;
      end
      StPlay: begin
        if (frame_tick) begin
          x_d  = mx;
          y_d  = my;
          dx_d = mdx;
          dy_d = mdy;
          if (miss_l) begin
            score_r_d = 1'b1;
            state_d   = StPoint;
          end else if (miss_r) begin
            score_l_d = 1'b1;
            state_d   = StPoint;
          end
        end
      end
      StPoint: begin
        // dx is frozen since the miss, so it already points at the conceding side.
        if (frame_tick) begin
          if (hold_q == HoldLast) begin
            state_d = StIdle;
            hold_d  = '0;
            x_d     = Cx[9:0];
            y_d     = Cy[9:0];
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    in_play_d = (state_d == StPlay);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= Cx[9:0];
      y_q       <= Cy[9:0];
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      hold_q    <= '0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      in_play_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      hold_q    <= hold_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      in_play_q <= in_play_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign in_play     = in_play_q;
  assign score_l_evt = score_l_q;
  assign score_r_evt = score_r_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboard bench for pong_ball_ctrl: stimulus queues hand-computed expectations
// tagged with the clock edge they apply after; a monitor compares on the falling edge.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       score_l_evt;
  logic       score_r_evt;

  pong_ball_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .serve       (serve),
    .paddle_l_y  (paddle_l_y),
    .paddle_r_y  (paddle_r_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .in_play     (in_play),
    .score_l_evt (score_l_evt),
    .score_r_evt (score_r_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ip;
    logic        sl;
    logic        sr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  int unsigned edge_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;
  int          n_sl     = 0;
  int          n_sr     = 0;
  int          n_both   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if (mon_e.at != edge_cnt || ball_x != mon_e.x || ball_y != mon_e.y ||
          in_play != mon_e.ip || score_l_evt != mon_e.sl || score_r_evt != mon_e.sr) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d in_play=%0b sl=%0b sr=%0b, expected x=%0d y=%0d in_play=%0b sl=%0b sr=%0b (edge %0d vs %0d)",
                 mon_nm, ball_x, ball_y, in_play, score_l_evt, score_r_evt,
                 mon_e.x, mon_e.y, mon_e.ip, mon_e.sl, mon_e.sr, edge_cnt, mon_e.at);
      end
    end
    if (score_l_evt) n_sl++;
    if (score_r_evt) n_sr++;
    if (score_l_evt && score_r_evt) n_both++;
  end

  task automatic push(input string nm, input int unsigned at, input int x, input int y,
                      input logic ip, input logic sl, input logic sr);
    exp_t e;
    e.at = at;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.ip = ip;
    e.sl = sl;
    e.sr = sr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic expect_next(input string nm, input int x, input int y,
                             input logic ip, input logic sl, input logic sr);
    push(nm, edge_cnt + 1, x, y, ip, sl, sr);
  endtask

  task automatic step(input logic t, input logic s);
    @(negedge clk);
    frame_tick = t;
    serve      = s;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic tick_chk(input string nm, input int x, input int y,
                          input logic ip, input logic sl, input logic sr);
    step(1'b1, 1'b0);
    expect_next(nm, x, y, ip, sl, sr);
    step(1'b0, 1'b0);
  endtask

  task automatic final_chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    paddle_l_y = 10'd300;
    paddle_r_y = 10'd200;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_next("reset_state", 316, 236, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) tick_chk("idle_tick", 316, 236, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1);
    expect_next("serve", 316, 236, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) tick_chk("play_start", 316 + 2 * i, 236 + 2 * i, 1'b1, 1'b0, 1'b0);

    // Rally 1: bottom bounce, right paddle hit, then a left miss.
    paddle_r_y = 10'd380;
    ticks(113);
    tick_chk("pre_bottom", 550, 470, 1'b1, 1'b0, 1'b0);
    tick_chk("bottom_bounce", 552, 472, 1'b1, 1'b0, 1'b0);
    tick_chk("after_bottom", 554, 470, 1'b1, 1'b0, 1'b0);
    ticks(26);
    tick_chk("rpaddle_hit", 608, 416, 1'b1, 1'b0, 1'b0);
    tick_chk("after_rhit", 606, 414, 1'b1, 1'b0, 1'b0);
    ticks(302);
    tick_chk("at_left_edge", 0, 190, 1'b1, 1'b0, 1'b0);
    tick_chk("left_miss", 0, 192, 1'b0, 1'b0, 1'b1);
    expect_next("miss_pulse_end", 0, 192, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1);
    expect_next("serve_in_point", 0, 192, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    ticks(59);
    expect_next("point_hold", 0, 192, 1'b0, 1'b0, 1'b0);
    tick_chk("point_done", 316, 236, 1'b0, 1'b0, 1'b0);
    tick_chk("idle_after_point", 316, 236, 1'b0, 1'b0, 1'b0);

    // Rally 2: serves left after the right player scored, hits the left paddle.
    step(1'b1, 1'b1);
    expect_next("serve_with_tick", 316, 236, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    paddle_l_y = 10'd380;
    tick_chk("serve_dir_left", 314, 238, 1'b1, 1'b0, 1'b0);
    ticks(143);
    tick_chk("pre_lhit", 26, 418, 1'b1, 1'b0, 1'b0);
    tick_chk("lpaddle_hit", 24, 416, 1'b1, 1'b0, 1'b0);
    tick_chk("after_lhit", 26, 414, 1'b1, 1'b0, 1'b0);
    ticks(9);
    tick_chk("mid_rally", 46, 394, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset with no clock edge before the check.
    @(posedge clk);
    #1 reset = 1'b1;
    push("reset_mid", edge_cnt, 316, 236, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b1);
    expect_next("serve_tick_after_reset", 316, 236, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    tick_chk("after_reset_tick", 318, 238, 1'b1, 1'b0, 1'b0);

    repeat (3) step(1'b0, 1'b0);
    @(posedge clk);
    #1;
    final_chk("pending_expectations", exp_q.size(), 0);
    final_chk("score_r_pulse_cycles", n_sr, 1);
    final_chk("score_l_pulse_cycles", n_sl, 0);
    final_chk("both_scores_at_once", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
